// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receive path: state encoding,
// parity codes, oversampling constants and the parity check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_SAMPLE  = 7;
    localparam int unsigned LAST_SAMPLE = OVERSAMPLE - 1;

    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = 3;

    // High when the data word plus received parity bit fail the selected rule.
    function automatic logic parity_error(input logic word_xor,
                                          input logic par_bit,
                                          input logic odd);
        return word_xor ^ par_bit ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Receive-line conditioning: 2-FF synchroniser for rxd and a one-cycle tick
// on each rising edge of the 16x baud enable.
module uart_rx_sync (
    input  logic clk25,
    input  logic rst,
    input  logic clk16,
    input  logic rxd,
    output logic rxd_s,
    output logic tick_c
);

    logic rxd_meta;
    logic clk16_d;

    // Flops reset high so an idle line and a high clk16 give no event after reset.
    always_ff @(posedge clk25) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            clk16_d  <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            clk16_d  <= clk16;
        end
    end

    assign tick_c = clk16 & ~clk16_d;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: start, DATA_BITS LSB-first, optional
// parity, one stop bit; byte strobe with parity and framing error flags.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0
) (
    input  logic                 clk25,
    input  logic                 rst,
    input  logic                 clk16,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam logic [OS_W-1:0]  OS_MID     = OS_W'(MID_SAMPLE);
    localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(LAST_SAMPLE);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic             HAS_PARITY = (PARITY_MODE != PARITY_NONE);
    localparam logic             ODD_RULE   = (PARITY_MODE == PARITY_ODD);

    logic rxd_s;
    logic tick;

    uart_rx_sync u_sync (
        .clk25  (clk25),
        .rst    (rst),
        .clk16  (clk16),
        .rxd    (rxd),
        .rxd_s  (rxd_s),
        .tick_c (tick)
    );

    rx_state_t            state, state_nxt;
    logic [OS_W-1:0]      os_cnt, os_nxt, os_inc;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 perr, perr_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 perr_out_nxt;
    logic                 ferr_nxt;
    logic                 busy_nxt;

    // State, counters and registered outputs.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            perr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            state      <= state_nxt;
            os_cnt     <= os_nxt;
            bit_cnt    <= bit_nxt;
            shift      <= shift_nxt;
            perr       <= perr_nxt;
            rx_data    <= data_nxt;
            rx_valid   <= valid_nxt;
            parity_err <= perr_out_nxt;
            frame_err  <= ferr_nxt;
            rx_busy    <= busy_nxt;
        end
    end

    assign os_inc = os_cnt + OS_W'(1);

    // Frame sequencing; every transition is qualified by the oversample tick.
    always_comb begin
        state_nxt    = state;
        os_nxt       = os_cnt;
        bit_nxt      = bit_cnt;
        shift_nxt    = shift;
        perr_nxt     = perr;
        data_nxt     = rx_data;
        valid_nxt    = 1'b0;
        perr_out_nxt = 1'b0;
        ferr_nxt     = 1'b0;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = START;
                        os_nxt    = '0;
                    end
                end
                START: begin
                    os_nxt = os_inc;
                    // Detection tick counts as sample 0, so the 7th tick after it is mid start bit.
                    if (os_inc == OS_MID) begin
                        if (!rxd_s) begin
                            state_nxt = DATA;
                            os_nxt    = '0;
                            bit_nxt   = '0;
                            perr_nxt  = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    os_nxt = os_inc;
                    if (os_cnt == OS_LAST) begin
                        shift_nxt = {rxd_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state_nxt = HAS_PARITY ? PARITY : STOP;
                        end else begin
                            bit_nxt = bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    os_nxt = os_inc;
                    if (os_cnt == OS_LAST) begin
                        perr_nxt  = parity_error(^shift, rxd_s, ODD_RULE);
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    os_nxt = os_inc;
                    if (os_cnt == OS_LAST) begin
                        if (rxd_s) begin
                            data_nxt     = shift;
                            valid_nxt    = 1'b1;
                            perr_out_nxt = perr;
                            state_nxt    = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A held-low line must return high before a new start is accepted.
                    if (rxd_s) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
